// File: rtl/t03_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package t03_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_INSTR_DEFAULT = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/t03_fetch_unit.sv
// Single-outstanding instruction fetch: request, hold the word until consumed,
// trap permanently on a misaligned fetch address.
module t03_fetch_unit
    import t03_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = RESET_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] cur_addr,
    input  logic [31:0] next_addr,
    input  logic        stall,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        freeze_pc,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         imem_ren_q, imem_ren_d;
    logic [31:0]  imem_addr_q, imem_addr_d;
    logic         misaligned_q, misaligned_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            ST_IDLE: begin
                addr_d  = cur_addr;
                state_d = is_misaligned(cur_addr) ? ST_ERR : ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_VALID;
                end else begin
                    state_d       = ST_REQ;
                end
            end
            ST_VALID: begin
                if (!stall) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    instr_valid_d = 1'b0;
                    addr_d        = next_addr;
                    state_d       = is_misaligned(next_addr) ? ST_ERR : ST_REQ;
                end else begin
                    state_d       = ST_VALID;
                end
            end
            ST_ERR: begin
                instr_valid_d = 1'b0;
                state_d       = ST_ERR;
            end
            default: begin
                instr_valid_d = 1'b0;
                state_d       = ST_ERR;
            end
        endcase
        // Memory-side outputs are registered from the next state so they line up with it.
        imem_ren_d   = (state_d == ST_REQ);
        imem_addr_d  = addr_d;
        misaligned_d = (state_d == ST_ERR);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            addr_q        <= 32'h0000_0000;
            instr_q       <= RESET_INSTR;
            instr_valid_q <= 1'b0;
            imem_ren_q    <= 1'b0;
            imem_addr_q   <= 32'h0000_0000;
            misaligned_q  <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_ren_q    <= imem_ren_d;
            imem_addr_q   <= imem_addr_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // The PC may only advance in the exact cycle an instruction is consumed.
    always_comb begin
        freeze_pc = !((state_q == ST_VALID) && !stall);
    end

    assign imem_ren    = imem_ren_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misaligned  = misaligned_q;
    assign fetch_count = fetch_count_q;

endmodule
